imm_decode_stage: RTL

//  Pipelined, parametrised immediate-extraction stage for the decode side of the RISC-V pipeline.

---
 rtl/imm_pkg.sv | 28 ++
 rtl/imm_extract.sv | 60 ++++++
 rtl/imm_decode_stage.sv | 110 +++++++++++
 3 files changed

// File: rtl/imm_pkg.sv
// Shared types and constants for the RISC-V immediate decode stage.
package imm_pkg;

    localparam int unsigned ILEN  = 32;
    localparam int unsigned FMT_W = 3;
    localparam int unsigned OPC_W = 7;

    typedef enum logic [FMT_W-1:0] {
        IMM_NONE = 3'd0,
        IMM_I    = 3'd1,
        IMM_S    = 3'd2,
        IMM_B    = 3'd3,
        IMM_U    = 3'd4,
        IMM_J    = 3'd5,
        IMM_CI   = 3'd6,
        IMM_CJ   = 3'd7
    } imm_fmt_e;

    localparam logic [OPC_W-1:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [OPC_W-1:0] OPC_LOAD   = 7'b0000011;
    localparam logic [OPC_W-1:0] OPC_JALR   = 7'b1100111;
    localparam logic [OPC_W-1:0] OPC_STORE  = 7'b0100011;
    localparam logic [OPC_W-1:0] OPC_BRANCH = 7'b1100011;
    localparam logic [OPC_W-1:0] OPC_LUI    = 7'b0110111;
    localparam logic [OPC_W-1:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [OPC_W-1:0] OPC_JAL    = 7'b1101111;

endpackage

// File: rtl/imm_extract.sv
// Combinational immediate extraction: instruction word -> sign-extended immediate + format code.
// Compressed (RVC) decode is compiled in only when IMM_RVC_EN is defined.
module imm_extract
    import imm_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [ILEN-1:0] instr,
    output logic [XLEN-1:0] imm,
    output imm_fmt_e        fmt
);

    logic [ILEN-1:0] imm32;

    // Every format is built as a 32-bit sign-extended value, then widened to XLEN.
    always_comb begin
        imm32 = '0;
        fmt   = IMM_NONE;
`ifdef IMM_RVC_EN
        if (instr[1:0] != 2'b11) begin
            if (instr[1:0] == 2'b01 && (instr[15:13] == 3'b000 || instr[15:13] == 3'b010)) begin
                fmt   = IMM_CI;
                imm32 = {{26{instr[12]}}, instr[12], instr[6:2]};
            end else if (instr[1:0] == 2'b01 && instr[15:13] == 3'b101) begin
                fmt   = IMM_CJ;
                imm32 = {{20{instr[12]}}, instr[12], instr[8], instr[10:9], instr[6],
                         instr[7], instr[2], instr[11], instr[5:3], 1'b0};
            end
        end else
`endif
        begin
            case (instr[OPC_W-1:0])
                OPC_OPIMM, OPC_LOAD, OPC_JALR: begin
                    fmt   = IMM_I;
                    imm32 = {{20{instr[31]}}, instr[31:20]};
                end
                OPC_STORE: begin
                    fmt   = IMM_S;
                    imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
                end
                OPC_BRANCH: begin
                    fmt   = IMM_B;
                    imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
                end
                OPC_LUI, OPC_AUIPC: begin
                    fmt   = IMM_U;
                    imm32 = {instr[31:12], 12'b0};
                end
                OPC_JAL: begin
                    fmt   = IMM_J;
                    imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
                end
                default: ;
            endcase
        end
    end

    assign imm = XLEN'($signed(imm32));

endmodule

// File: rtl/imm_decode_stage.sv
// Pipelined immediate decode stage: decode, then an output register backed by a one-entry skid.
// Optional compressed-instruction decode is enabled by defining IMM_RVC_EN.
module imm_decode_stage
    import imm_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned TAG_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [ILEN-1:0]  instr_i,
    input  logic [TAG_W-1:0] tag_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [XLEN-1:0]  imm_o,
    output imm_fmt_e         imm_fmt_o,
    output logic [TAG_W-1:0] tag_o
);

    logic [XLEN-1:0]  dec_imm;
    imm_fmt_e         dec_fmt;

    logic             skid_valid, skid_valid_d;
    logic [XLEN-1:0]  skid_imm, skid_imm_d;
    imm_fmt_e         skid_fmt, skid_fmt_d;
    logic [TAG_W-1:0] skid_tag, skid_tag_d;

    logic             out_valid_d, in_ready_d;
    logic [XLEN-1:0]  out_imm_d;
    imm_fmt_e         out_fmt_d;
    logic [TAG_W-1:0] out_tag_d;

    logic             accept, out_free;

    imm_extract #(.XLEN(XLEN)) u_extract (
        .instr (instr_i),
        .imm   (dec_imm),
        .fmt   (dec_fmt)
    );

    assign accept   = in_valid_i && in_ready_o;
    assign out_free = !out_valid_o || out_ready_i;

    // Next-state: skid drains into the output before any new word, keeping FIFO order.
    always_comb begin
        out_valid_d  = out_valid_o;
        out_imm_d    = imm_o;
        out_fmt_d    = imm_fmt_o;
        out_tag_d    = tag_o;
        skid_valid_d = skid_valid;
        skid_imm_d   = skid_imm;
        skid_fmt_d   = skid_fmt;
        skid_tag_d   = skid_tag;

        if (flush_i) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (out_free) begin
            if (skid_valid) begin
                out_valid_d  = 1'b1;
                out_imm_d    = skid_imm;
                out_fmt_d    = skid_fmt;
                out_tag_d    = skid_tag;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                out_valid_d = 1'b1;
                out_imm_d   = dec_imm;
                out_fmt_d   = dec_fmt;
                out_tag_d   = tag_i;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (accept) begin
            skid_valid_d = 1'b1;
            skid_imm_d   = dec_imm;
            skid_fmt_d   = dec_fmt;
            skid_tag_d   = tag_i;
        end

        in_ready_d = !skid_valid_d;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_valid_o <= 1'b0;
            in_ready_o  <= 1'b1;
            imm_o       <= '0;
            imm_fmt_o   <= IMM_NONE;
            tag_o       <= '0;
            skid_valid  <= 1'b0;
            skid_imm    <= '0;
            skid_fmt    <= IMM_NONE;
            skid_tag    <= '0;
        end else begin
            out_valid_o <= out_valid_d;
            in_ready_o  <= in_ready_d;
            imm_o       <= out_imm_d;
            imm_fmt_o   <= out_fmt_d;
            tag_o       <= out_tag_d;
            skid_valid  <= skid_valid_d;
            skid_imm    <= skid_imm_d;
            skid_fmt    <= skid_fmt_d;
            skid_tag    <= skid_tag_d;
        end
    end

endmodule
